non_restoring_divider: RTL and testbench

- Multi-cycle integer divider with a WIDTH parameter. It uses a non-restoring algorithm and produces one quotient bit per cycle.
- Returns quotient and remainder for unsigned or signed operands.
- Sits beside the CPU ALU. The CPU instantiates it twice, at WIDTH=32 and WIDTH=64, for DIV/MOD instructions.
- The CPU pulses enable for one cycle, then polls data_ready.

---
 rtl/non_restoring_divider_pkg.sv | 19 +
 rtl/non_restoring_divider_iter_step.sv | 21 ++
 rtl/non_restoring_divider.sv | 111 +++++++++++
 tb/tb_non_restoring_divider.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/non_restoring_divider_pkg.sv
// Shared types and constants for the non-restoring divider.
// Holds the FSM state encoding, sign-mode codes and the fixed latency helper.
package pkg_divider;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2
   } div_state_t;

   localparam logic DIV_UNSIGNED = 1'b0;
   localparam logic DIV_SIGNED   = 1'b1;

   // Edges from the accepting edge to the edge that raises data_ready.
   function automatic int div_latency(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/non_restoring_divider_iter_step.sv
// One non-restoring add/subtract step on the {P,Q} pair, purely combinational.
// Zero latency; no flow control.
module nrd_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   p_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH:0]   p_o,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH:0] p_sh;
   logic [WIDTH:0] d_ext;

   // The add/subtract choice follows the sign of P before the shift.
   assign p_sh  = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
   assign d_ext = {1'b0, d_i};
   assign p_o   = p_i[WIDTH] ? (p_sh + d_ext) : (p_sh - d_ext);
   assign q_o   = {q_i[WIDTH-2:0], ~p_o[WIDTH]};

endmodule

// File: rtl/non_restoring_divider.sv
// Multi-cycle non-restoring divider, one quotient bit per cycle, unsigned or signed.
// Latency WIDTH+1 edges accept-to-data_ready; enable is ignored while busy (no queueing).
// NON_RESTORING_DIVIDER_DIV0_BYPASS_EN: a zero divisor skips BUSY and finishes one edge after accept.
module non_restoring_divider
   import pkg_divider::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             unsgn_or_sgn,
   input  logic [WIDTH-1:0] num,
   input  logic [WIDTH-1:0] denom,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             can_accept_cmd,
   output logic             data_ready
);
   localparam int CW = $clog2(WIDTH);

   div_state_t       state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   p_q, p_d;
   logic [WIDTH-1:0] q_q, q_d, d_q, num_q, quot_q, rem_q;
   logic             neg_quot_q, neg_rem_q, div0_q, rdy_q, can_q;

   logic             num_neg, den_neg;
   logic [WIDTH-1:0] num_mag, den_mag, rem_mag, quot_fix, rem_fix;

   assign num_neg = (unsgn_or_sgn == DIV_SIGNED) && num[WIDTH-1];
   assign den_neg = (unsgn_or_sgn == DIV_SIGNED) && denom[WIDTH-1];
   assign num_mag = num_neg ? -num : num;
   assign den_mag = den_neg ? -denom : denom;

   nrd_iter_step #(.WIDTH(WIDTH)) u_step (
      .p_i (p_q),
      .q_i (q_q),
      .d_i (d_q),
      .p_o (p_d),
      .q_o (q_d)
   );

   // Restore a negative final remainder, apply signs; a zero divisor overrides both.
   assign rem_mag  = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
   assign quot_fix = div0_q ? '1    : (neg_quot_q ? -q_q : q_q);
   assign rem_fix  = div0_q ? num_q : (neg_rem_q ? -rem_mag : rem_mag);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         p_q        <= '0;
         q_q        <= '0;
         d_q        <= '0;
         num_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         div0_q     <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         rdy_q      <= 1'b0;
         can_q      <= 1'b1;
      end else begin
         rdy_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable) begin
                  p_q        <= '0;
                  q_q        <= num_mag;
                  d_q        <= den_mag;
                  num_q      <= num;
                  neg_quot_q <= num_neg ^ den_neg;
                  neg_rem_q  <= num_neg;
                  div0_q     <= (denom == '0);
                  cnt_q      <= CW'(WIDTH - 1);
                  can_q      <= 1'b0;
`ifdef NON_RESTORING_DIVIDER_DIV0_BYPASS_EN
                  state_q    <= (denom == '0) ? FIX : BUSY;
`else
                  state_q    <= BUSY;
`endif
               end
            end
            BUSY: begin
               p_q <= p_d;
               q_q <= q_d;
               if (cnt_q == '0) begin
                  state_q <= FIX;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            FIX: begin
               quot_q  <= quot_fix;
               rem_q   <= rem_fix;
               rdy_q   <= 1'b1;
               can_q   <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign quot           = quot_q;
   assign rem            = rem_q;
   assign data_ready     = rdy_q;
   assign can_accept_cmd = can_q;

endmodule

// File: tb/tb_non_restoring_divider.sv
// Self-checking bench for non_restoring_divider at WIDTH=32 and WIDTH=64.
// Expected results come from plain integer arithmetic with the divider's special cases.
module tb_non_restoring_divider;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        en32 = 1'b0, s32 = 1'b0;
   logic [31:0] n32 = '0, d32 = '0, quot32, rem32;
   logic        can32, rdy32;

   logic        en64 = 1'b0, s64 = 1'b0;
   logic [63:0] n64 = '0, d64 = '0, quot64, rem64;
   logic        can64, rdy64;

   int total = 0;
   int passed = 0;

   localparam int LAT32 = 33;
   localparam int LAT64 = 65;
`ifdef NON_RESTORING_DIVIDER_DIV0_BYPASS_EN
   localparam int LAT0_32 = 1;
   localparam int LAT0_64 = 1;
`else
   localparam int LAT0_32 = LAT32;
   localparam int LAT0_64 = LAT64;
`endif

   non_restoring_divider #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .enable(en32), .unsgn_or_sgn(s32),
      .num(n32), .denom(d32), .quot(quot32), .rem(rem32),
      .can_accept_cmd(can32), .data_ready(rdy32)
   );

   non_restoring_divider #(.WIDTH(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .enable(en64), .unsgn_or_sgn(s64),
      .num(n64), .denom(d64), .quot(quot64), .rem(rem64),
      .can_accept_cmd(can64), .data_ready(rdy64)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic void model32(input logic s, input logic [31:0] n, input logic [31:0] d,
                                   output logic [31:0] q, output logic [31:0] r);
      if (d == 0) begin
         q = '1; r = n;
      end else if (!s) begin
         q = n / d; r = n % d;
      end else if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
         q = n; r = '0;
      end else begin
         q = $signed(n) / $signed(d); r = $signed(n) % $signed(d);
      end
   endfunction

   function automatic void model64(input logic s, input logic [63:0] n, input logic [63:0] d,
                                   output logic [63:0] q, output logic [63:0] r);
      if (d == 0) begin
         q = '1; r = n;
      end else if (!s) begin
         q = n / d; r = n % d;
      end else if (n == 64'h8000_0000_0000_0000 && d == '1) begin
         q = n; r = '0;
      end else begin
         q = $signed(n) / $signed(d); r = $signed(n) % $signed(d);
      end
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic issue32(input logic s, input logic [31:0] n, input logic [31:0] d);
      en32 = 1'b1; s32 = s; n32 = n; d32 = d;
      @(negedge clk);
      en32 = 1'b0;
   endtask

   task automatic wait32(input string tag, input logic [31:0] eq, input logic [31:0] er, input int lat);
      int n = 0;
      int early = 0;
      while (!rdy32 && n < 200) begin
         if (can32) early++;
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(lat));
      chk({tag, " can_low"}, 64'(early), 64'd0);
      chk({tag, " quot"}, {32'd0, quot32}, {32'd0, eq});
      chk({tag, " rem"}, {32'd0, rem32}, {32'd0, er});
   endtask

   task automatic op32(input string tag, input logic s, input logic [31:0] n, input logic [31:0] d);
      logic [31:0] eq, er;
      model32(s, n, d, eq, er);
      issue32(s, n, d);
      wait32(tag, eq, er, (d == 0) ? LAT0_32 : LAT32);
      @(negedge clk);
      chk({tag, " pulse"}, {63'd0, rdy32}, 64'd0);
      chk({tag, " can_back"}, {63'd0, can32}, 64'd1);
   endtask

   task automatic op64(input string tag, input logic s, input logic [63:0] n, input logic [63:0] d);
      logic [63:0] eq, er;
      int cyc = 0;
      model64(s, n, d, eq, er);
      en64 = 1'b1; s64 = s; n64 = n; d64 = d;
      @(negedge clk);
      en64 = 1'b0;
      while (!rdy64 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, " latency"}, 64'(cyc), 64'((d == 0) ? LAT0_64 : LAT64));
      chk({tag, " quot"}, quot64, eq);
      chk({tag, " rem"}, rem64, er);
      @(negedge clk);
      chk({tag, " pulse"}, {63'd0, rdy64}, 64'd0);
   endtask

   initial begin
      logic [31:0] eq, er, rn, rd;
      logic        rs;
      int          seen;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst quot", {32'd0, quot32}, 64'd0);
      chk("rst rem", {32'd0, rem32}, 64'd0);
      chk("rst can", {63'd0, can32}, 64'd1);
      chk("rst rdy", {63'd0, rdy32}, 64'd0);
      chk("rst quot64", quot64, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      op32("u100/7", 1'b0, 32'd100, 32'd7);
      op32("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      op32("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
      op32("sMIN/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      op32("u5/0", 1'b0, 32'd5, 32'd0);
      op32("s5/0", 1'b1, 32'd5, 32'd0);
      op32("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0);
      op32("u3/10", 1'b0, 32'd3, 32'd10);
      op32("uMAX/1", 1'b0, 32'hFFFF_FFFF, 32'd1);

      // Enable while busy with different operands is ignored
      model32(1'b0, 32'd1000, 32'd3, eq, er);
      issue32(1'b0, 32'd1000, 32'd3);
      repeat (5) @(negedge clk);
      issue32(1'b0, 32'd50, 32'd5);
      wait32("busy_en", eq, er, LAT32 - 6);
      @(negedge clk);
      chk("busy_en pulse", {63'd0, rdy32}, 64'd0);

      // Second command issued in the data_ready cycle
      model32(1'b0, 32'd20, 32'd6, eq, er);
      issue32(1'b0, 32'd20, 32'd6);
      wait32("b2b first", eq, er, LAT32);
      issue32(1'b0, 32'hFFFF_FFFF, 32'h10);
      wait32("b2b second", 32'h0FFF_FFFF, 32'hF, LAT32);
      @(negedge clk);

      // Reset mid-operation aborts without a result
      issue32(1'b0, 32'd77, 32'd5);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort quot", {32'd0, quot32}, 64'd0);
      chk("abort rem", {32'd0, rem32}, 64'd0);
      chk("abort can", {63'd0, can32}, 64'd1);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         if (rdy32) seen++;
         @(negedge clk);
      end
      chk("abort no_rdy", 64'(seen), 64'd0);

      // Randomized operands against the arithmetic model
      for (int i = 0; i < 16; i++) begin
         rs = 1'($urandom_range(0, 1));
         rn = $urandom;
         case ($urandom_range(0, 3))
            0:       rd = 32'($urandom_range(0, 3));
            1:       rd = 32'($urandom_range(1, 1000));
            2:       rd = -32'($urandom_range(1, 1000));
            default: rd = $urandom;
         endcase
         op32($sformatf("rand%0d", i), rs, rn, rd);
      end

      // 64-bit instance
      op64("u64 max/3", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
      op64("s64 MIN/-1", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      op64("u64 9/0", 1'b0, 64'd9, 64'd0);
      for (int i = 0; i < 4; i++) begin
         op64($sformatf("rand64_%0d", i), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {32'($urandom_range(0, 15)), $urandom});
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
